// File: rtl/rvmyth_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// rvmyth_ctrl_pkg : shared state encoding, default bus width, counter sizing
// Rev 1.0
// ============================================================================
package rvmyth_ctrl_pkg;

  localparam int OUT_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_RUN      = 3'd2,
    ST_STOP     = 3'd3,
    ST_DONE     = 3'd4
  } run_state_e;

  // Wide enough to hold the largest terminal count plus one without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvmyth_out_capture.sv
`default_nettype none
// ============================================================================
// rvmyth_out_capture : OUT-bus change detect into a one-entry valid/ready reg
// Rev 1.0
// ============================================================================
module rvmyth_out_capture
  import rvmyth_ctrl_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             cap_en_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o,
  output logic             overflow_o,
  output logic             change_o
);

  logic [OUT_W-1:0] prev_q;
  logic [OUT_W-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;
  logic             change;

  assign change = cap_en_i && (data_i != prev_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (load_i || cap_en_i) prev_q <= data_i;
      if (clear_i) begin
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (change) begin
        // A full register that is not being drained loses the new sample.
        if (!valid_q || ready_i) begin
          data_q  <= data_i;
          valid_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;
  assign change_o   = change;

endmodule
`default_nettype wire

// File: rtl/rvmyth_run_ctrl.sv
`default_nettype none
// ============================================================================
// rvmyth_run_ctrl : run sequencer for the rvmyth core (reset hold, run, stop)
// Optional macro RUN_CTRL_STABLE_EN ends a run after STABLE_CYCLES idle OUT.
// Rev 1.0
// ============================================================================
module rvmyth_run_ctrl
  import rvmyth_ctrl_pkg::*;
#(
  parameter int OUT_W         = OUT_W_DEF,
  parameter int RST_CYCLES    = 60,
  parameter int RUN_CYCLES    = 500,
  parameter int STABLE_CYCLES = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic [OUT_W-1:0] cpu_out,
  output logic             cpu_reset,
  output logic             cpu_clk_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(RST_CYCLES, RUN_CYCLES, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             start_ok;
  logic             change;
  logic             stable_hit;

  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef RUN_CTRL_STABLE_EN
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  logic [CNT_W-1:0] stab_q, stab_d;

  assign stable_hit = (state_q == ST_RUN) && !change && (stab_q == STAB_LAST);

  always_comb begin
    stab_d = '0;
    if (state_q == ST_RUN) stab_d = change ? '0 : stab_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) stab_q <= '0;
    else       stab_q <= stab_d;
  end
`else
  logic unused_change;
  assign unused_change = change;
  assign stable_hit    = 1'b0;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RST_HOLD;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ST_RST_HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (halt_req) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end else if (cnt_q == RST_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Priority: explicit halt, then quiet OUT bus, then watchdog.
        if (halt_req || stable_hit) begin
          state_d = ST_STOP;
          cnt_d   = '0;
        end else if (cnt_q == RUN_LAST) begin
          state_d   = ST_STOP;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      ST_STOP: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_reset  = 1'b1;
    cpu_clk_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_RST_HOLD: begin
        cpu_clk_en = 1'b1;
        busy       = 1'b1;
      end
      ST_RUN: begin
        cpu_reset  = 1'b0;
        cpu_clk_en = 1'b1;
        busy       = 1'b1;
      end
      ST_STOP: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign timeout = timeout_q;

  rvmyth_out_capture #(
    .OUT_W(OUT_W)
  ) u_cap (
    .clk_i      (CLK),
    .rst_i      (reset),
    .clear_i    (start_ok),
    .load_i     ((state_q == ST_RST_HOLD) && (state_d == ST_RUN)),
    .cap_en_i   (state_q == ST_RUN),
    .data_i     (cpu_out),
    .ready_i    (out_ready),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .overflow_o (overflow),
    .change_o   (change)
  );

endmodule
`default_nettype wire

// File: tb/tb_rvmyth_run_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rvmyth_run_ctrl : randomized bench against a phase/countdown reference
// Rev 1.0
// ============================================================================
module tb_rvmyth_run_ctrl;

  localparam int OUT_W         = 10;
  localparam int RST_CYCLES    = 60;
  localparam int RUN_CYCLES    = 500;
  localparam int STABLE_CYCLES = 32;
`ifdef RUN_CTRL_STABLE_EN
  localparam bit STAB_EN = 1'b1;
`else
  localparam bit STAB_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             halt_req = 1'b0;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] cpu_out = '0;
  logic             cpu_reset, cpu_clk_en, out_valid, busy, done, timeout, overflow;
  logic [OUT_W-1:0] out_data;

  rvmyth_run_ctrl #(
    .OUT_W(OUT_W), .RST_CYCLES(RST_CYCLES),
    .RUN_CYCLES(RUN_CYCLES), .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .halt_req(halt_req),
    .cpu_out(cpu_out), .cpu_reset(cpu_reset), .cpu_clk_en(cpu_clk_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .timeout(timeout), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: named phase plus cycles remaining in that phase.
  string            m_phase;
  int               m_left, m_quiet;
  logic             m_valid, m_over, m_tmo;
  logic [OUT_W-1:0] m_data, m_prev;

  task automatic model_reset();
    m_phase = "IDLE"; m_left = 0; m_quiet = 0;
    m_valid = 0; m_over = 0; m_tmo = 0; m_data = '0; m_prev = '0;
  endtask

  task automatic model_step();
    bit chg;
    chg = 0;
    if (m_phase == "RUN") begin
      chg = (cpu_out != m_prev);
      m_prev = cpu_out;
    end
    if (chg) begin
      if (!m_valid || out_ready) begin m_data = cpu_out; m_valid = 1; end
      else m_over = 1;
    end else if (m_valid && out_ready) m_valid = 0;

    if (m_phase == "IDLE" || m_phase == "DONE") begin
      if (start) begin
        m_phase = "RST_HOLD"; m_left = RST_CYCLES;
        m_tmo = 0; m_over = 0; m_valid = 0;
      end
    end else if (m_phase == "RST_HOLD") begin
      if (halt_req) m_phase = "STOP";
      else begin
        m_left--;
        if (m_left == 0) begin
          m_phase = "RUN"; m_left = RUN_CYCLES; m_prev = cpu_out; m_quiet = 0;
        end
      end
    end else if (m_phase == "RUN") begin
      m_left--;
      m_quiet = chg ? 0 : m_quiet + 1;
      if (halt_req) m_phase = "STOP";
      else if (STAB_EN && m_quiet == STABLE_CYCLES) m_phase = "STOP";
      else if (m_left == 0) begin m_phase = "STOP"; m_tmo = 1; end
    end else if (m_phase == "STOP") begin
      m_phase = "DONE";
    end
  endtask

  task automatic check_all();
    check("cpu_reset",  cpu_reset,  m_phase != "RUN");
    check("cpu_clk_en", cpu_clk_en, m_phase == "RST_HOLD" || m_phase == "RUN");
    check("busy",       busy,       m_phase == "RST_HOLD" || m_phase == "RUN" || m_phase == "STOP");
    check("done",       done,       m_phase == "DONE");
    check("timeout",    timeout,    m_tmo);
    check("overflow",   overflow,   m_over);
    check("out_valid",  out_valid,  m_valid);
    check("out_data",   out_data,   m_data);
  endtask

  task automatic cycle(input logic s, input logic h, input logic [OUT_W-1:0] o, input logic r);
    @(negedge CLK);
    check_all();
    start = s; halt_req = h; cpu_out = o; out_ready = r;
    @(posedge CLK);
    model_step();
  endtask

  task automatic rand_run(input int ncyc, input int halt_pm, input bit halt_at_wd, input int start_pct);
    logic [OUT_W-1:0] o;
    logic h, s;
    o = cpu_out;
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(0, 99) < 15)
        o = ($urandom_range(0, 3) == 0) ? OUT_W'($urandom) : o ^ OUT_W'(1 << $urandom_range(0, OUT_W-1));
      h = ($urandom_range(0, 999) < halt_pm);
      if (halt_at_wd && m_phase == "RUN" && m_left == 1) h = 1'b1;
      s = (i == 0) || ($urandom_range(0, 99) < start_pct);
      cycle(s, h, o, $urandom_range(0, 99) < 60);
    end
  endtask

  task automatic async_reset();
    @(negedge CLK);
    start = 0; halt_req = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    model_step();
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    repeat (3) @(negedge CLK);
    check_all();
    reset = 1'b0;
    @(posedge CLK);
    model_step();

    // Directed: reset hold, capture steps, overflow, drain, watchdog.
    cycle(0, 0, 10'h000, 1);
    cycle(1, 0, 10'h000, 1);
    repeat (RST_CYCLES + 2) cycle(0, 0, 10'h000, 1);
    repeat (3) cycle(0, 0, 10'h001, 1);
    repeat (3) cycle(0, 0, 10'h003, 1);
    cycle(0, 0, 10'h003, 0);
    cycle(0, 0, 10'h005, 0);
    cycle(0, 0, 10'h00A, 0);
    repeat (3) cycle(0, 0, 10'h00A, 0);
    check("ovf_hold_data", out_data, 10'h005);
    check("ovf_flag", overflow, 1'b1);
    repeat (3) cycle(0, 0, 10'h00A, 1);
    check("drained", out_valid, 1'b0);
    repeat (RUN_CYCLES) cycle(0, 0, 10'h00A, 1);
    check("wd_done", done, 1'b1);
    check("wd_timeout", timeout, !STAB_EN);

    // Halt during reset hold.
    cycle(1, 0, 10'h00A, 1);
    repeat (10) cycle(0, 0, 10'h00A, 1);
    cycle(0, 1, 10'h00A, 1);
    repeat (3) cycle(0, 0, 10'h00A, 1);
    check("rh_halt_done", done, 1'b1);

    // Halt coincident with the watchdog limit.
    rand_run(600, 0, 1'b1, 0);
    check("wd_halt_tmo", timeout, 1'b0);
    check("wd_halt_done", done, 1'b1);

    // Randomized runs with occasional halts and stray starts.
    repeat (6) rand_run(600, 2, 1'b0, 1);

    // Asynchronous reset in the middle of a run.
    rand_run(200, 0, 1'b0, 0);
    async_reset();
    rand_run(600, 1, 1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
